// File: rtl/pong_dmem_loader_if.sv
// Single data-memory write port (enable, address, data).
// The loader consumes the CPU side as slave and drives the memory side as master.
interface pong_dmem_loader_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport master (output wr_en, output wr_addr, output wr_data);
  modport slave  (input  wr_en, input  wr_addr, input  wr_data);
endinterface

// File: rtl/pong_dmem_loader.sv
// Loads the PONG initial image into the 16-byte data memory and
// arbitrates the memory write port between the loader and the CPU.
module pong_dmem_loader #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter bit AUTO_LOAD = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [DEPTH*DATA_W-1:0] init_bytes,
  input  logic                    cpu_ack,
  pong_dmem_loader_if.slave       cpu,
  pong_dmem_loader_if.master      mem,
  output logic                    cpu_stall,
  output logic                    busy,
  output logic                    done,
  output logic                    cpu_wr_dropped
);

  localparam int ADDR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_LOAD, S_DONE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= AUTO_LOAD ? S_REQ : S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Outside LOAD the CPU owns the write port combinationally.
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    cpu_stall      = 1'b0;
    busy           = 1'b0;
    done           = 1'b0;
    cpu_wr_dropped = 1'b0;
    mem.wr_en      = cpu.wr_en;
    mem.wr_addr    = cpu.wr_addr;
    mem.wr_data    = cpu.wr_data;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_REQ;
      end
      S_REQ: begin
        cpu_stall = 1'b1;
        busy      = 1'b1;
        if (cpu_ack) begin
          state_nxt = S_LOAD;
          cnt_nxt   = '0;
        end
      end
      S_LOAD: begin
        cpu_stall      = 1'b1;
        busy           = 1'b1;
        cpu_wr_dropped = cpu.wr_en;
        mem.wr_en      = 1'b1;
        mem.wr_addr    = cnt;
        mem.wr_data    = init_bytes[int'(cnt)*DATA_W +: DATA_W];
        // A late drop of cpu_ack does not abort the load once it has begun.
        if (cnt == ADDR_W'(DEPTH-1)) begin
          state_nxt = S_DONE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_pong_dmem_loader.sv
// Bench for pong_dmem_loader: one AUTO_LOAD=1 and one AUTO_LOAD=0 instance
// on a shared CPU port, checked against a word-count reference model.
module tb_pong_dmem_loader;
  localparam int DW = 8;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start_a = 1'b0, start_b = 1'b0, ack_a = 1'b0, ack_b = 1'b0;
  logic [DEPTH*DW-1:0] init_bytes;
  logic stall_a, busy_a, done_a, drop_a;
  logic stall_b, busy_b, done_b, drop_b;

  pong_dmem_loader_if #(.DATA_W(DW), .ADDR_W(4)) cpu_if ();
  pong_dmem_loader_if #(.DATA_W(DW), .ADDR_W(4)) mem_a_if ();
  pong_dmem_loader_if #(.DATA_W(DW), .ADDR_W(4)) mem_b_if ();

  pong_dmem_loader #(.DATA_W(DW), .DEPTH(DEPTH), .AUTO_LOAD(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .init_bytes(init_bytes), .cpu_ack(ack_a),
    .cpu(cpu_if), .mem(mem_a_if), .cpu_stall(stall_a), .busy(busy_a), .done(done_a),
    .cpu_wr_dropped(drop_a));

  pong_dmem_loader #(.DATA_W(DW), .DEPTH(DEPTH), .AUTO_LOAD(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .init_bytes(init_bytes), .cpu_ack(ack_b),
    .cpu(cpu_if), .mem(mem_b_if), .cpu_stall(stall_b), .busy(busy_b), .done(done_b),
    .cpu_wr_dropped(drop_b));

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: pending request, loading flag, words already written, done pulse.
  bit m_req[2], m_load[2], m_done[2];
  int m_idx[2];
  logic [7:0] img[16];
  logic [7:0] dmem[2][16];
  logic [11:0] wq_a[$], wq_b[$];
  int done_cnt_a, done_cnt_b;

  typedef struct {
    bit st; bit ak; bit en; logic [3:0] ad; logic [7:0] dt;
    bit e_stall; bit e_en; logic [3:0] e_ad; logic [7:0] e_dt; bit e_drop;
  } vec_t;
  vec_t tv[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_req[i]  = (i == 0);
      m_load[i] = 1'b0;
      m_done[i] = 1'b0;
      m_idx[i]  = 0;
    end
  endfunction

  function automatic void model_step();
    for (int i = 0; i < 2; i++) begin
      bit s, a;
      s = (i == 0) ? start_a : start_b;
      a = (i == 0) ? ack_a : ack_b;
      if (m_done[i]) m_done[i] = 1'b0;
      else if (m_load[i]) begin
        if (m_idx[i] == DEPTH - 1) begin
          m_load[i] = 1'b0;
          m_done[i] = 1'b1;
        end else m_idx[i]++;
      end else if (m_req[i]) begin
        if (a) begin
          m_req[i] = 1'b0; m_load[i] = 1'b1; m_idx[i] = 0;
        end
      end else if (s) m_req[i] = 1'b1;
    end
  endfunction

  task automatic sample();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      logic st, bz, dn, dr, en;
      logic [3:0] ad;
      logic [7:0] dt;
      bit ld;
      string tg;
      tg = (i == 0) ? "A" : "B";
      if (i == 0) begin
        st = stall_a; bz = busy_a; dn = done_a; dr = drop_a;
        en = mem_a_if.wr_en; ad = mem_a_if.wr_addr; dt = mem_a_if.wr_data;
      end else begin
        st = stall_b; bz = busy_b; dn = done_b; dr = drop_b;
        en = mem_b_if.wr_en; ad = mem_b_if.wr_addr; dt = mem_b_if.wr_data;
      end
      ld = m_load[i];
      chk({tg, ".cpu_stall"}, st, m_req[i] | ld);
      chk({tg, ".busy"}, bz, m_req[i] | ld);
      chk({tg, ".done"}, dn, m_done[i]);
      chk({tg, ".dropped"}, dr, ld & cpu_if.wr_en);
      chk({tg, ".wr_en"}, en, ld ? 1'b1 : cpu_if.wr_en);
      chk({tg, ".wr_addr"}, ad, ld ? 4'(m_idx[i]) : cpu_if.wr_addr);
      chk({tg, ".wr_data"}, dt, ld ? img[m_idx[i]] : cpu_if.wr_data);
      if (en === 1'b1 && rst_n) dmem[i][ad] = dt;
    end
    if (stall_a && mem_a_if.wr_en) wq_a.push_back({mem_a_if.wr_addr, mem_a_if.wr_data});
    if (stall_b && mem_b_if.wr_en) wq_b.push_back({mem_b_if.wr_addr, mem_b_if.wr_data});
    if (done_a) done_cnt_a++;
    if (done_b) done_cnt_b++;
  endtask

  task automatic advance();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step();
    #1;
  endtask

  task automatic check_writes(input string tag, input logic [11:0] q[$]);
    chk({tag, ".nwrites"}, q.size(), 16);
    for (int k = 0; k < q.size() && k < 16; k++) begin
      chk($sformatf("%s.addr%0d", tag, k), q[k][11:8], k);
      chk($sformatf("%s.data%0d", tag, k), q[k][7:0], img[k]);
    end
  endtask

  initial begin
    int stall_cnt, hold;
    bit hit;

    for (int k = 0; k < 16; k++) img[k] = 8'h00;
    img[4] = 8'h40; img[7] = 8'h04; img[9] = 8'h08;
    img[11] = 8'h01; img[12] = 8'h01; img[15] = 8'h03;
    for (int k = 0; k < 16; k++) init_bytes[8*k +: 8] = img[k];
    for (int k = 0; k < 16; k++) begin dmem[0][k] = 8'hFF; dmem[1][k] = 8'hFF; end
    cpu_if.wr_en = 1'b0; cpu_if.wr_addr = 4'h0; cpu_if.wr_data = 8'h00;

    tv[0] = '{0, 0, 1, 4'h6, 8'h5A, 0, 1, 4'h6, 8'h5A, 0};
    tv[1] = '{0, 0, 0, 4'h3, 8'h11, 0, 0, 4'h3, 8'h11, 0};
    tv[2] = '{1, 0, 0, 4'h0, 8'h00, 0, 0, 4'h0, 8'h00, 0};
    tv[3] = '{0, 0, 1, 4'h2, 8'hC3, 1, 1, 4'h2, 8'hC3, 0};
    tv[4] = '{0, 1, 0, 4'h0, 8'h00, 1, 0, 4'h0, 8'h00, 0};
    tv[5] = '{0, 0, 0, 4'h0, 8'h00, 1, 1, 4'h0, 8'h00, 0};
    tv[6] = '{0, 0, 0, 4'h9, 8'hFF, 1, 1, 4'h1, 8'h00, 0};
    tv[7] = '{0, 0, 1, 4'h6, 8'h5A, 1, 1, 4'h2, 8'h00, 1};
    tv[8] = '{0, 0, 0, 4'h0, 8'h00, 1, 1, 4'h3, 8'h00, 0};
    tv[9] = '{0, 0, 0, 4'h0, 8'h00, 1, 1, 4'h4, 8'h40, 0};

    // Power-on: A requests the port, B stays idle.
    #2 rst_n = 1'b0;
    model_reset();
    ack_a = 1'b1;
    sample();
    chk("por.stall_a", stall_a, 1); chk("por.wr_en_a", mem_a_if.wr_en, 0);
    chk("por.done_a", done_a, 0);   chk("por.stall_b", stall_b, 0);
    advance();
    rst_n = 1'b1;
    wq_a.delete(); done_cnt_a = 0;
    for (int k = 0; k < 40 && done_cnt_a == 0; k++) begin sample(); advance(); end
    check_writes("auto", wq_a);
    chk("auto.done_pulses", done_cnt_a, 1);
    sample();
    chk("auto.stall_after", stall_a, 0);
    advance();

    // Table: pass-through in IDLE, honoured write in REQ, dropped write in LOAD.
    for (int r = 0; r < 10; r++) begin
      start_b = tv[r].st; ack_b = tv[r].ak;
      cpu_if.wr_en = tv[r].en; cpu_if.wr_addr = tv[r].ad; cpu_if.wr_data = tv[r].dt;
      sample();
      chk($sformatf("tv%0d.stall", r), stall_b, tv[r].e_stall);
      chk($sformatf("tv%0d.wr_en", r), mem_b_if.wr_en, tv[r].e_en);
      chk($sformatf("tv%0d.wr_addr", r), mem_b_if.wr_addr, tv[r].e_ad);
      chk($sformatf("tv%0d.wr_data", r), mem_b_if.wr_data, tv[r].e_dt);
      chk($sformatf("tv%0d.dropped", r), drop_b, tv[r].e_drop);
      advance();
    end
    start_b = 1'b0; ack_b = 1'b0; cpu_if.wr_en = 1'b0;
    done_cnt_b = 0;
    for (int k = 0; k < 30 && done_cnt_b == 0; k++) begin sample(); advance(); end
    chk("drop.done", done_cnt_b, 1);
    chk("drop.addr6", dmem[1][6], 8'h00);
    chk("drop.addr2", dmem[1][2], 8'h00);
    chk("drop.addr4", dmem[1][4], 8'h40);

    // Start with cpu_ack delayed: five REQ cycles, then the sixteen writes.
    start_b = 1'b1; ack_b = 1'b0;
    sample(); advance();
    start_b = 1'b0;
    wq_b.delete(); done_cnt_b = 0; stall_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      sample();
      if (stall_b) stall_cnt++;
      chk("req.no_write", mem_b_if.wr_en, 0);
      advance();
    end
    ack_b = 1'b1;
    for (int k = 0; k < 30 && done_cnt_b == 0; k++) begin
      sample();
      if (stall_b) stall_cnt++;
      advance();
    end
    ack_b = 1'b0;
    chk("ackdly.stall_cycles", stall_cnt, 21);
    chk("ackdly.done", done_cnt_b, 1);
    check_writes("ackdly", wq_b);

    // start re-asserted while loading at cnt 7 is ignored.
    start_a = 1'b1;
    sample(); advance();
    start_a = 1'b0;
    wq_a.delete(); done_cnt_a = 0; hit = 0; hold = 0;
    for (int k = 0; k < 24; k++) begin
      sample();
      if (!hit && stall_a && mem_a_if.wr_en && mem_a_if.wr_addr == 4'd7) begin
        hit = 1; start_a = 1'b1; hold = 3;
      end
      advance();
      if (hold > 0) begin hold--; if (hold == 0) start_a = 1'b0; end
    end
    chk("restart.hit_cnt7", hit, 1);
    chk("restart.done_pulses", done_cnt_a, 1);
    check_writes("restart", wq_a);

    // Reset mid-load at cnt 9, then a full reload from word 0.
    start_a = 1'b1;
    sample(); advance();
    start_a = 1'b0;
    hit = 0;
    for (int k = 0; k < 20; k++) begin
      sample();
      if (stall_a && mem_a_if.wr_en && mem_a_if.wr_addr == 4'd9) begin hit = 1; break; end
      advance();
    end
    chk("rst9.hit_cnt9", hit, 1);
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst9.wr_en", mem_a_if.wr_en, 0);
    chk("rst9.done", done_a, 0);
    chk("rst9.stall", stall_a, 1);
    advance();
    rst_n = 1'b1;
    wq_a.delete(); done_cnt_a = 0;
    for (int k = 0; k < 30 && done_cnt_a == 0; k++) begin sample(); advance(); end
    chk("rst9.done_after", done_cnt_a, 1);
    check_writes("rst9", wq_a);

    // Random traffic against the model.
    for (int k = 0; k < 400; k++) begin
      start_a = ($urandom_range(0, 9) == 0);
      start_b = ($urandom_range(0, 9) == 0);
      ack_a = $urandom_range(0, 1);
      ack_b = $urandom_range(0, 1);
      cpu_if.wr_en = $urandom_range(0, 1);
      cpu_if.wr_addr = 4'($urandom);
      cpu_if.wr_data = 8'($urandom);
      if ($urandom_range(0, 149) == 0) begin
        rst_n = 1'b0;
        model_reset();
      end else rst_n = 1'b1;
      sample();
      advance();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
